// File: rtl/ysyx_store_queue_pkg.sv
// Shared definitions for the committed-store queue and its lane formatter.
package ysyx_store_queue_pkg;

    localparam int YSYX_XLEN = 32;

    // Store size codes as carried on the ROU alu field.
    localparam logic [4:0] ALU_SB = 5'd8;
    localparam logic [4:0] ALU_SH = 5'd9;
    localparam logic [4:0] ALU_SW = 5'd10;

    // Drain FSM state encoding.
    typedef logic [0:0] sq_state_t;
    localparam sq_state_t S_IDLE  = 1'b0;
    localparam sq_state_t S_WRITE = 1'b1;

    // One buffered store, exactly as retired by the ROU.
    typedef struct packed {
        logic [4:0]           alu;
        logic [YSYX_XLEN-1:0] waddr;
        logic [YSYX_XLEN-1:0] wdata;
    } sq_entry_t;

endpackage

// File: rtl/ysyx_store_queue_strb.sv
// Combinational lane formatter: turns a store size and byte offset into
// bus byte strobes and lane-replicated write data.
module ysyx_sq_strb
    import ysyx_store_queue_pkg::*;
#(
    parameter int XLEN = YSYX_XLEN
) (
    input  logic [4:0]        alu_i,
    input  logic [1:0]        off_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o
);

    localparam int NB = XLEN / 8;

    localparam logic [NB-1:0] MASK_B = NB'(4'h1);
    localparam logic [NB-1:0] MASK_H = NB'(4'h3);
    localparam logic [NB-1:0] MASK_W = NB'(4'hF);

    // Replicate the low bytes across every lane so the slave can pick any lane.
    always_comb begin
        wstrb_o = '0;
        wdata_o = wdata_i;
        case (alu_i)
            ALU_SB: begin
                wstrb_o = MASK_B << off_i;
                wdata_o = {NB{wdata_i[7:0]}};
            end
            ALU_SH: begin
                wstrb_o = MASK_H << off_i;
                wdata_o = {(NB/2){wdata_i[15:0]}};
            end
            ALU_SW: begin
                wstrb_o = MASK_W << off_i;
                wdata_o = {(NB/4){wdata_i[31:0]}};
            end
            default: begin
                wstrb_o = '0;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_store_queue.sv
// Committed-store buffer between the ROU and the bus arbiter. Retired stores
// are queued and drained one at a time; pending stores block aliasing loads.
// XLEN must match the package width used by sq_entry_t.
module ysyx_store_queue
    import ysyx_store_queue_pkg::*;
#(
    parameter int XLEN    = YSYX_XLEN,
    parameter int SQ_SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rou_valid,
    input  logic            rou_store,
    input  logic [4:0]      rou_alu,
    input  logic [XLEN-1:0] rou_waddr,
    input  logic [XLEN-1:0] rou_wdata,
    output logic            sq_ready,
    output logic            sq_empty,
    input  logic [XLEN-1:0] ld_raddr,
    output logic            ld_hit,
    output logic            bus_awvalid,
    output logic [XLEN-1:0] bus_awaddr,
    output logic            bus_wvalid,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wstrb,
    input  logic            bus_wready
);

    localparam int IW = $clog2(SQ_SIZE);
    localparam int PW = IW + 1;
    localparam int NB = XLEN / 8;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    sq_state_t       state_q, state_d;
    logic            awvalid_q, awvalid_d;
    logic [XLEN-1:0] awaddr_q, awaddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;

    sq_entry_t       mem_q [SQ_SIZE];
    sq_entry_t       head_entry;

    logic            enq;
    logic            full;
    logic            ptr_low_equal;
    logic [PW-1:0]   occupancy;
    logic [NB-1:0]   fmt_strb;
    logic [XLEN-1:0] fmt_data;
    logic            unused_ld_lsbs;

    // Same low bits with differing wrap bits means the tail lapped the head.
    assign ptr_low_equal = (head_q[IW-1:0] == tail_q[IW-1:0]);
    assign full          = ptr_low_equal && (head_q[IW] != tail_q[IW]);
    assign occupancy     = tail_q - head_q;
    assign enq           = rou_valid && rou_store && !full;
    assign head_entry    = mem_q[head_q[IW-1:0]];

    assign sq_ready    = !full;
    assign sq_empty    = (head_q == tail_q) && (state_q == S_IDLE);
    assign bus_awvalid = awvalid_q;
    assign bus_wvalid  = awvalid_q;
    assign bus_awaddr  = awaddr_q;
    assign bus_wdata   = wdata_q;
    assign bus_wstrb   = wstrb_q;

    assign unused_ld_lsbs = ^ld_raddr[1:0];

    ysyx_sq_strb #(
        .XLEN (XLEN)
    ) u_fmt (
        .alu_i   (head_entry.alu),
        .off_i   (head_entry.waddr[1:0]),
        .wdata_i (head_entry.wdata),
        .wstrb_o (fmt_strb),
        .wdata_o (fmt_data)
    );

    // Entry storage needs no reset: validity is tracked purely by the pointers.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem_q[tail_q[IW-1:0]] <= '{alu: rou_alu, waddr: rou_waddr, wdata: rou_wdata};
        end
    end

    // Pointer update and drain FSM; the head is popped only once the bus accepts it.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        state_d   = state_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (head_q != tail_q) begin
                    state_d   = S_WRITE;
                    awvalid_d = 1'b1;
                    awaddr_d  = {head_entry.waddr[XLEN-1:2], 2'b00};
                    wdata_d   = fmt_data;
                    wstrb_d   = 8'(fmt_strb);
                end
            end
            S_WRITE: begin
                if (bus_wready) begin
                    head_d    = head_q + PW'(1);
                    state_d   = S_IDLE;
                    awvalid_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
            end
        endcase
    end

    // Reset abandons any in-flight write and clears the bus side immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // Hazard check: any live entry (in-flight head included) in the same word blocks the load.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            if (({1'b0, IW'(i) - head_q[IW-1:0]} < occupancy) &&
                (mem_q[i].waddr[XLEN-1:2] == ld_raddr[XLEN-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    // Flag illegal enqueues and unsupported misaligned stores as they reach the head.
    always @(posedge clock) begin
        if (reset) begin
            assert (!(rou_valid && rou_store && full));
            if ((state_q == S_IDLE) && (head_q != tail_q)) begin
                assert (!((head_entry.alu == ALU_SH) && (head_entry.waddr[1:0] == 2'd3)));
                assert (!((head_entry.alu == ALU_SW) && (head_entry.waddr[1:0] != 2'd0)));
            end
        end
    end

endmodule

// File: tb/tb_ysyx_store_queue.sv
// Self-checking bench for ysyx_store_queue: directed scenarios plus a randomized
// stream, checked against a FIFO reference model of the committed stores.
module tb_ysyx_store_queue;
    import ysyx_store_queue_pkg::*;

    localparam int XLEN    = 32;
    localparam int SQ_SIZE = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            rou_valid;
    logic            rou_store;
    logic [4:0]      rou_alu;
    logic [XLEN-1:0] rou_waddr;
    logic [XLEN-1:0] rou_wdata;
    logic            sq_ready;
    logic            sq_empty;
    logic [XLEN-1:0] ld_raddr;
    logic            ld_hit;
    logic            bus_awvalid;
    logic [XLEN-1:0] bus_awaddr;
    logic            bus_wvalid;
    logic [XLEN-1:0] bus_wdata;
    logic [7:0]      bus_wstrb;
    logic            bus_wready;

    typedef struct {
        logic [4:0]  alu;
        logic [31:0] addr;
        logic [31:0] data;
    } ref_t;

    ref_t modelQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   popCount  = 0;

    ysyx_store_queue #(
        .XLEN    (XLEN),
        .SQ_SIZE (SQ_SIZE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rou_valid   (rou_valid),
        .rou_store   (rou_store),
        .rou_alu     (rou_alu),
        .rou_waddr   (rou_waddr),
        .rou_wdata   (rou_wdata),
        .sq_ready    (sq_ready),
        .sq_empty    (sq_empty),
        .ld_raddr    (ld_raddr),
        .ld_hit      (ld_hit),
        .bus_awvalid (bus_awvalid),
        .bus_awaddr  (bus_awaddr),
        .bus_wvalid  (bus_wvalid),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_wready  (bus_wready)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference lane formatting: lane b is enabled when it falls inside the
    // store's byte span, and carries data byte (b mod size).
    function automatic void expFormat(input ref_t e, output logic [7:0] strb, output logic [31:0] data);
        int size;
        int off;
        size = (e.alu == ALU_SB) ? 1 : (e.alu == ALU_SH) ? 2 : 4;
        off  = int'(e.addr[1:0]);
        strb = 8'h00;
        data = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + size) strb[b] = 1'b1;
            data[8*b +: 8] = e.data[8*(b % size) +: 8];
        end
    endfunction

    function automatic logic modelHit();
        foreach (modelQ[k]) begin
            if (modelQ[k].addr[31:2] == ld_raddr[31:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic [4:0] alu, input logic [31:0] addr, input logic [31:0] data);
        rou_valid = 1'b1;
        rou_store = 1'b1;
        rou_alu   = alu;
        rou_waddr = addr;
        rou_wdata = data;
    endtask

    task automatic idleRou();
        rou_valid = 1'b0;
        rou_store = 1'b0;
    endtask

    // One clock: score any handshake, update the model, then check status outputs.
    task automatic tick();
        ref_t        e;
        logic [7:0]  es;
        logic [31:0] ed;
        logic        hs;
        logic        enq;
        hs  = bus_awvalid && bus_wready;
        enq = rou_valid && rou_store && sq_ready;
        if (hs) begin
            if (modelQ.size() == 0) begin
                checkOutput("spurious_write", bus_awvalid, 1'b0);
            end else begin
                e = modelQ.pop_front();
                expFormat(e, es, ed);
                checkOutput("sb_awaddr", bus_awaddr, {e.addr[31:2], 2'b00});
                checkOutput("sb_wstrb", bus_wstrb, es);
                checkOutput("sb_wdata", bus_wdata, ed);
                popCount++;
            end
        end
        if (enq) begin
            e.alu  = rou_alu;
            e.addr = rou_waddr;
            e.data = rou_wdata;
            modelQ.push_back(e);
        end
        @(posedge clock);
        #1;
        checkOutput("sq_ready", sq_ready, modelQ.size() < SQ_SIZE);
        checkOutput("sq_empty", sq_empty, modelQ.size() == 0);
        checkOutput("ld_hit", ld_hit, modelHit());
    endtask

    task automatic drainAll(input int budget);
        int n;
        n = 0;
        bus_wready = 1'b1;
        idleRou();
        while (modelQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", sq_empty, 1'b1);
    endtask

    // Single store from an empty, idle queue with the bus always ready.
    task automatic runSingle(input string tag, input logic [4:0] alu, input logic [31:0] addr,
                             input logic [31:0] data, input logic [7:0] expStrb, input logic [31:0] expData);
        bus_wready = 1'b1;
        applyStimulus(alu, addr, data);
        tick();
        idleRou();
        checkOutput({tag, "_awvalid_early"}, bus_awvalid, 1'b0);
        tick();
        checkOutput({tag, "_awvalid"}, bus_awvalid, 1'b1);
        checkOutput({tag, "_wvalid"}, bus_wvalid, 1'b1);
        checkOutput({tag, "_awaddr"}, bus_awaddr, {addr[31:2], 2'b00});
        checkOutput({tag, "_wstrb"}, bus_wstrb, expStrb);
        checkOutput({tag, "_wdata"}, bus_wdata, expData);
        tick();
        checkOutput({tag, "_awvalid_done"}, bus_awvalid, 1'b0);
        checkOutput({tag, "_empty_done"}, sq_empty, 1'b1);
    endtask

    initial begin
        int          sent;
        int          popsStart;
        int          k;
        logic [1:0]  off;
        logic [4:0]  alu;
        rou_valid  = 1'b0;
        rou_store  = 1'b0;
        rou_alu    = ALU_SW;
        rou_waddr  = '0;
        rou_wdata  = '0;
        ld_raddr   = 32'hFFFF_FFF0;
        bus_wready = 1'b0;

        // Reset values while reset is held low.
        #12;
        checkOutput("rst_ready", sq_ready, 1'b1);
        checkOutput("rst_empty", sq_empty, 1'b1);
        checkOutput("rst_awvalid", bus_awvalid, 1'b0);
        checkOutput("rst_wvalid", bus_wvalid, 1'b0);
        checkOutput("rst_awaddr", bus_awaddr, 32'h0);
        checkOutput("rst_wdata", bus_wdata, 32'h0);
        checkOutput("rst_wstrb", bus_wstrb, 8'h00);
        checkOutput("rst_ldhit", ld_hit, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single word store, then byte and halfword lane placement.
        runSingle("sw", ALU_SW, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'hDEAD_BEEF);
        runSingle("sb", ALU_SB, 32'h8000_0003, 32'h0000_00AB, 8'h08, 32'hABAB_ABAB);
        runSingle("sh", ALU_SH, 32'h8000_0022, 32'h0000_1234, 8'h0C, 32'h1234_1234);

        // Fill to capacity under backpressure.
        bus_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ALU_SW, 32'h0000_1000 + 32'(16 * i), $urandom);
            tick();
        end
        idleRou();
        checkOutput("full_ready", sq_ready, 1'b0);
        checkOutput("full_awvalid", bus_awvalid, 1'b1);
        bus_wready = 1'b1;
        tick();
        checkOutput("first_pop_ready", sq_ready, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("occ2_inflight", bus_awvalid, 1'b1);
        // Enqueue and pop together at occupancy two.
        applyStimulus(ALU_SB, 32'h0000_2001, 32'h0000_0055);
        tick();
        bus_wready = 1'b0;
        applyStimulus(ALU_SH, 32'h0000_2100, 32'h0000_BEEF);
        tick();
        checkOutput("occ3_ready", sq_ready, 1'b1);
        applyStimulus(ALU_SW, 32'h0000_2200, 32'h0BAD_F00D);
        tick();
        checkOutput("occ4_ready", sq_ready, 1'b0);
        drainAll(60);

        // Load hazard against a pending word store.
        bus_wready = 1'b0;
        applyStimulus(ALU_SW, 32'h0000_0100, 32'h1111_2222);
        tick();
        idleRou();
        ld_raddr = 32'h0000_0102;
        tick();
        checkOutput("hz_same_word", ld_hit, 1'b1);
        ld_raddr = 32'h0000_0104;
        tick();
        checkOutput("hz_next_word", ld_hit, 1'b0);
        drainAll(20);
        ld_raddr = 32'h0000_0102;
        tick();
        checkOutput("hz_after_drain", ld_hit, 1'b0);

        // Reset in the middle of a stalled write.
        bus_wready = 1'b0;
        applyStimulus(ALU_SW, 32'h8000_0040, 32'h1122_3344);
        tick();
        idleRou();
        tick();
        checkOutput("mid_awvalid", bus_awvalid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_awvalid", bus_awvalid, 1'b0);
        checkOutput("mid_rst_wvalid", bus_wvalid, 1'b0);
        checkOutput("mid_rst_empty", sq_empty, 1'b1);
        checkOutput("mid_rst_ready", sq_ready, 1'b1);
        checkOutput("mid_rst_awaddr", bus_awaddr, 32'h0);
        checkOutput("mid_rst_wstrb", bus_wstrb, 8'h00);
        checkOutput("mid_rst_ldhit", ld_hit, 1'b0);
        modelQ.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        runSingle("post_rst", ALU_SW, 32'h8000_0080, 32'hCAFE_F00D, 8'h0F, 32'hCAFE_F00D);

        // Randomized stream across the pointer wrap with random bus stalls.
        sent      = 0;
        popsStart = popCount;
        for (int cyc = 0; cyc < 400 && sent < 10; cyc++) begin
            bus_wready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                ld_raddr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            end
            if (sq_ready && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 2);
                alu = (k == 0) ? ALU_SB : (k == 1) ? ALU_SH : ALU_SW;
                off = (k == 0) ? 2'($urandom_range(0, 3)) : (k == 1) ? 2'($urandom_range(0, 2)) : 2'd0;
                applyStimulus(alu, 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'(off), $urandom);
                sent++;
            end else begin
                idleRou();
                if ($urandom_range(0, 7) == 0) rou_valid = 1'b1;
            end
            tick();
        end
        drainAll(100);
        checkOutput("rand_writes", popCount - popsStart, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_store_queue.md
Name: ysyx_store_queue

Overview:
- Committed-store buffer sitting between the ROU and the memory bus arbiter.
- Accepts retired stores on the ROU→LSU channel, holds them in a FIFO, and drains them one at a time over the store half of the LSU bus channel (awvalid/wvalid/wready).
- Flags load-address hazards against pending stores so the load path stalls.
- Reports empty so fence/fence.i retirement can wait for the drain to complete.

Parameters:
- XLEN, `YSYX_XLEN (32): address/data width.
- SQ_SIZE, 4: entry count; must be a power of two, ≥2.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserts low; outputs to reset values immediately).
- rou_valid  in  1  ROU presents a committed store this cycle.
- rou_store  in  1  entry is a store; rou_valid with rou_store=0 is ignored.
- rou_alu  in  5  store size code: SB/SH/SW from the shared package.
- rou_waddr  in  XLEN  byte address.
- rou_wdata  in  XLEN  unaligned (LSB-justified) store data.
- sq_ready  out  1  queue not full; ROU may enqueue.
- sq_empty  out  1  no valid entries and no write in flight.
- ld_raddr  in  XLEN  address of the load being issued.
- ld_hit  out  1  a pending store matches ld_raddr word; load must stall.
- bus_awvalid  out  1  write address valid.
- bus_awaddr  out  XLEN  word-aligned address (low 2 bits zero).
- bus_wvalid  out  1  write data valid; always equal to bus_awvalid.
- bus_wdata  out  XLEN  lane-shifted data.
- bus_wstrb  out  8  byte strobes; bits [7:4] always 0 for XLEN=32.
- bus_wready  in  1  bus accepted and completed the write.

Behaviour:
- Storage: SQ_SIZE entries {alu, waddr, wdata}. Head/tail pointers are $clog2(SQ_SIZE)+1 bits wide; the extra MSB distinguishes full from empty. Wrap-around is modulo 2·SQ_SIZE.
- Enqueue: on rou_valid & rou_store & sq_ready, write at tail, tail+1. Enqueue while sq_ready=0 is illegal; the entry is dropped and the bench assertion fires.
- sq_ready = !full, combinational from registered pointers.
- Drain FSM:
  - S_IDLE: if the queue is non-empty, latch head into the output registers and go to S_WRITE.
  - S_WRITE: bus_awvalid/bus_wvalid=1, holding all bus outputs stable until bus_wready. On bus_wready: pop head (head+1), go to S_IDLE.
  - bus_awvalid is registered. Enqueue into an empty queue at edge t raises awvalid after edge t+1, i.e. 2 cycles of latency.
  - Peak throughput is 1 store per 2 cycles.
- Strobe and data generation, with off = waddr[1:0]:
  - SB: strb=4'b0001<<off, data=wdata[7:0] replicated to all lanes.
  - SH: strb=4'b0011<<off, data=wdata[15:0] replicated ×2. Misaligned SH (off=3) is not supported and is checked by an assertion.
  - SW: strb=4'b1111, data=wdata. off≠0 is not supported and is checked by an assertion.
- ld_hit: OR over valid entries, including the in-flight head, of waddr[XLEN-1:2]==ld_raddr[XLEN-1:2]. Comparison is word-granular and conservative. A same-cycle enqueue is not visible until the next cycle.
- sq_empty = (head==tail) & state==S_IDLE.
- Simultaneous enqueue and pop when full: legal only if sq_ready was 1, so never while full. Enqueue and pop in the same cycle at any other occupancy leaves the count unchanged.
- Reset (any time, including mid-write):
  - head=tail=0, state=S_IDLE.
  - bus_awvalid=bus_wvalid=0; bus_awaddr=bus_wdata=0; bus_wstrb=0.
  - sq_ready=1, sq_empty=1, ld_hit=0.
  - The interrupted write is abandoned; the bus side must also be reset.
- No flush input: entries are architecturally committed and always drain.

Decomposition:
- Shared package (ysyx.svh / ysyx_pkg) holds:
  - store size codes SB/SH/SW as 5-bit alu constants;
  - sq_entry_t struct {alu, waddr, wdata};
  - the state enum {S_IDLE, S_WRITE}.
- One natural sub-module: ysyx_sq_strb, a combinational alu+offset → {wstrb, wdata} lane formatter, reused by load-side alignment checks.
- Storage and FSM remain in ysyx_store_queue.

Test Plan:
- Single SW: enqueue addr=0x8000_0010, data=0xDEADBEEF, wready tied 1 → awvalid rises 2 edges after enqueue; awaddr=0x8000_0010, wstrb=0x0F, wdata=0xDEADBEEF; sq_empty returns to 1 one cycle after the handshake.
- SB/SH lanes: SB addr=0x...03, data=0xAB → wstrb=0x08, wdata=0xABABABAB; SH addr=0x...02, data=0x1234 → wstrb=0x0C, wdata=0x12341234.
- Full/backpressure: wready=0; enqueue 4 stores → sq_ready=0 after the 4th. Release wready → 4 writes drain in FIFO order, sq_ready returns 1 after the first pop. An enqueue-and-pop in the same cycle at occupancy 2 keeps occupancy 2.
- Load hazard: pending SW to 0x100 → ld_raddr=0x102 gives ld_hit=1, ld_raddr=0x104 gives ld_hit=0. After the drain completes, ld_raddr=0x102 gives ld_hit=0.
- Reset mid-write: assert reset low while awvalid=1 with wready=0 → awvalid=0 and sq_empty=1 immediately. After release, a new SW drains normally with pointers restarted at 0.
- Pointer wrap: stream 10 stores with random wready stalls → bus order and data match a scoreboard; no loss or duplication across the 2·SQ_SIZE wrap.
